// File: rtl/syscall_print_unit_pkg.sv
// Shared syscall codes, FSM encoding, ASCII constants and BCD helpers for
// syscall_print_unit.
package syscall_print_unit_pkg;

  localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
  localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
  localparam logic [31:0] SYS_EXIT       = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
  localparam logic [31:0] SYS_PRINT_HEX  = 32'd34;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_X     = 8'h78;

  typedef enum logic [3:0] {
    IDLE,
    STR_REQ,
    STR_WAIT,
    STR_EMIT,
    INT_CONV,
    INT_EMIT,
    CHAR_EMIT,
    DONE,
    HALTED
  } state_e;

  typedef struct packed {
    logic [39:0] digits;
    logic [3:0]  count;
  } bcd_align_t;

  // Left-justify the BCD so the most significant non-zero digit sits in the
  // top nibble; at least one digit is always kept so zero prints as "0".
  function automatic bcd_align_t align_bcd(input logic [39:0] bcd);
    bcd_align_t r;
    r.digits = bcd;
    r.count  = 4'd10;
    for (int i = 0; i < 9; i++) begin
      if (r.digits[39:36] == 4'd0) begin
        r.digits = {r.digits[35:0], 4'h0};
        r.count  = r.count - 4'd1;
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] digit_ascii(input logic [3:0] d, input logic hex);
    if (hex && (d > 4'd9)) return 8'h57 + {4'h0, d};
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/syscall_print_unit_if.sv
// Core/memory/console bundle for syscall_print_unit; slave = the unit,
// master = its environment.
interface syscall_print_unit_if #(
  parameter int ADDR_W = 32
);
  logic              syscall_valid;
  logic [31:0]       v0;
  logic [31:0]       a0;
  logic              stall;
  logic              done;
  logic              halt;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              char_valid;
  logic [7:0]        char_data;
  logic              char_ready;

  modport slave (
    input  syscall_valid, v0, a0, mem_rdata, char_ready,
    output stall, done, halt, mem_ren, mem_addr, char_valid, char_data
  );

  modport master (
    output syscall_valid, v0, a0, mem_rdata, char_ready,
    input  stall, done, halt, mem_ren, mem_addr, char_valid, char_data
  );
endinterface

// File: rtl/syscall_print_unit_bin2bcd.sv
// syscall_bin2bcd: fixed 32-iteration double-dabble, 32-bit binary to 10 BCD
// digits; done pulses for one cycle with bcd_o valid.
module syscall_bin2bcd (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [31:0] mag_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [39:0] bcd_o
);
  logic [31:0] bin_q, bin_d;
  logic [39:0] bcd_q, bcd_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [39:0] adj;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 10; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_i) begin
      bin_d  = mag_i;
      bcd_d  = '0;
      cnt_d  = 6'd32;
      busy_d = 1'b1;
    end else if (busy_q) begin
      bcd_d = {adj[38:0], bin_q[31]};
      bin_d = {bin_q[30:0], 1'b0};
      cnt_d = cnt_q - 6'd1;
      if (cnt_q == 6'd1) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;
endmodule

// File: rtl/syscall_print_unit.sv
// syscall_print_unit: stalls the core while servicing print/exit syscalls and
// streams ASCII to the console. Optional hex printing (v0=34) with SYSCALL_HEX_EN.
import syscall_print_unit_pkg::*;

module syscall_print_unit #(
  parameter int MAX_STR_LEN = 1024,
  parameter int ADDR_W      = 32
) (
  input logic clk,
  input logic reset,
  syscall_print_unit_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_STR_LEN + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        char_q, char_d;
  logic [39:0]       digits_q, digits_d;
  logic [3:0]        ndig_q, ndig_d;
  logic [1:0]        pre_q, pre_d;
  logic              hex_q, hex_d;
  logic              halt_seen_q;

  logic        conv_start, conv_busy, conv_done;
  logic [31:0] conv_mag;
  logic [39:0] conv_bcd;
  logic [7:0]  rd_byte;
  bcd_align_t  aligned;

  syscall_bin2bcd u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .start_i (conv_start),
    .mag_i   (conv_mag),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  assign rd_byte  = bus.mem_rdata[{ptr_q[1:0], 3'b000} +: 8];
  assign aligned  = align_bcd(conv_bcd);
  assign conv_mag = bus.a0[31] ? (~bus.a0 + 32'd1) : bus.a0;
  assign bus.halt = (state_q == HALTED);

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    count_d        = count_q;
    char_d         = char_q;
    digits_d       = digits_q;
    ndig_d         = ndig_q;
    pre_d          = pre_q;
    hex_d          = hex_q;
    conv_start     = 1'b0;
    bus.stall      = 1'b0;
    bus.done       = 1'b0;
    bus.mem_ren    = 1'b0;
    bus.mem_addr   = '0;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;

    case (state_q)
      IDLE: begin
        if (bus.syscall_valid) begin
          bus.stall = 1'b1;
          case (bus.v0)
            SYS_PRINT_INT: begin
              conv_start = 1'b1;
              pre_d      = {1'b0, bus.a0[31]};
              hex_d      = 1'b0;
              state_d    = INT_CONV;
            end
            SYS_PRINT_STR: begin
              ptr_d   = bus.a0[ADDR_W-1:0];
              count_d = '0;
              state_d = STR_REQ;
            end
            SYS_EXIT:       state_d = HALTED;
            SYS_PRINT_CHAR: begin
              char_d  = bus.a0[7:0];
              state_d = CHAR_EMIT;
            end
`ifdef SYSCALL_HEX_EN
            SYS_PRINT_HEX: begin
              digits_d = {bus.a0, 8'h00};
              ndig_d   = 4'd8;
              pre_d    = 2'd2;
              hex_d    = 1'b1;
              state_d  = INT_EMIT;
            end
`endif
            default:        state_d = DONE;
          endcase
        end
      end
      STR_REQ: begin
        bus.stall    = 1'b1;
        bus.mem_ren  = 1'b1;
        bus.mem_addr = {ptr_q[ADDR_W-1:2], 2'b00};
        state_d      = STR_WAIT;
      end
      STR_WAIT: begin
        bus.stall = 1'b1;
        char_d    = rd_byte;
        state_d   = (rd_byte == 8'h00) ? DONE : STR_EMIT;
      end
      STR_EMIT: begin
        bus.stall      = 1'b1;
        bus.char_valid = 1'b1;
        bus.char_data  = char_q;
        if (bus.char_ready) begin
          ptr_d   = ptr_q + 1'b1;
          count_d = count_q + 1'b1;
          state_d = (count_d == CNT_W'(MAX_STR_LEN)) ? DONE : STR_REQ;
        end
      end
      INT_CONV: begin
        bus.stall = 1'b1;
        if (conv_done && !conv_busy) begin
          digits_d = aligned.digits;
          ndig_d   = aligned.count;
          state_d  = INT_EMIT;
        end
      end
      INT_EMIT: begin
        bus.stall      = 1'b1;
        bus.char_valid = 1'b1;
        // Prefix characters ('-' or "0x") go out before the digit nibbles.
        if (pre_q != 2'd0)
          bus.char_data = hex_q ? ((pre_q == 2'd2) ? ASCII_ZERO : ASCII_X) : ASCII_MINUS;
        else
          bus.char_data = digit_ascii(digits_q[39:36], hex_q);
        if (bus.char_ready) begin
          if (pre_q != 2'd0) begin
            pre_d = pre_q - 2'd1;
          end else begin
            digits_d = {digits_q[35:0], 4'h0};
            ndig_d   = ndig_q - 4'd1;
            if (ndig_q == 4'd1) state_d = DONE;
          end
        end
      end
      CHAR_EMIT: begin
        bus.stall      = 1'b1;
        bus.char_valid = 1'b1;
        bus.char_data  = char_q;
        if (bus.char_ready) state_d = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      HALTED:  bus.done = !halt_seen_q;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      count_q     <= '0;
      char_q      <= '0;
      digits_q    <= '0;
      ndig_q      <= '0;
      pre_q       <= '0;
      hex_q       <= 1'b0;
      halt_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      char_q      <= char_d;
      digits_q    <= digits_d;
      ndig_q      <= ndig_d;
      pre_q       <= pre_d;
      hex_q       <= hex_d;
      halt_seen_q <= (state_q == HALTED);
    end
  end
endmodule

// File: tb/tb_syscall_print_unit.sv
// Self-checking bench for syscall_print_unit: directed and $urandom syscalls
// checked against a string-level reference model; SYSCALL_HEX_EN selects hex cases.
module tb_syscall_print_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  syscall_print_unit_if #(.ADDR_W(32)) bus();

  syscall_print_unit #(.MAX_STR_LEN(1024), .ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:4095];
  logic [7:0] gotQ[$];
  logic [7:0] expQ[$];
  int readyMode = 0;
  int doneCnt = 0, holdViol = 0, stallDoneViol = 0, addrViol = 0;
  logic prevHold = 1'b0;
  logic [7:0] prevData = 8'h00;

  // Sink readiness changes shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    case (readyMode)
      0: bus.char_ready = 1'b1;
      1: bus.char_ready = ~bus.char_ready;
      2: bus.char_ready = 1'($urandom_range(0, 1));
      default: bus.char_ready = 1'b0;
    endcase
  end

  // Data memory: word read, data returned the cycle after mem_ren.
  always @(posedge clk) begin
    if (bus.mem_ren) begin
      logic [11:0] a;
      a = {bus.mem_addr[11:2], 2'b00};
      bus.mem_rdata <= {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
      if (bus.mem_addr[1:0] != 2'b00) addrViol++;
    end
  end

  // Console-side monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      prevHold = 1'b0;
    end else begin
      if (prevHold && (!bus.char_valid || bus.char_data !== prevData)) holdViol++;
      if (bus.char_valid && bus.char_ready) gotQ.push_back(bus.char_data);
      if (bus.done) begin
        doneCnt++;
        if (bus.stall) stallDoneViol++;
      end
      prevHold = bus.char_valid && !bus.char_ready;
      prevData = bus.char_data;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] v0, input logic [31:0] a0,
                               input int limit, output int cycles);
    @(posedge clk); #1;
    bus.v0 = v0;
    bus.a0 = a0;
    bus.syscall_valid = 1'b1;
    cycles = 0;
    while (1) begin
      @(negedge clk);
      cycles++;
      if (bus.done || cycles >= limit) break;
    end
    checkOutput("done_seen", {63'd0, bus.done}, 64'd1);
    @(posedge clk); #1;
    bus.syscall_valid = 1'b0;
  endtask

  task automatic compareStream(input string tag, input int base);
    checkOutput({tag, "_len"}, 64'(gotQ.size() - base), 64'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++)
      if (base + i < gotQ.size())
        checkOutput($sformatf("%s_b%0d", tag, i), {56'd0, gotQ[base + i]}, {56'd0, expQ[i]});
  endtask

  function automatic void modelInt(input logic [31:0] a0);
    longint v;
    logic [7:0] t[$];
    expQ.delete();
    v = longint'($signed(a0));
    if (v < 0) begin
      expQ.push_back(8'h2D);
      v = -v;
    end
    do begin
      t.push_front(8'(48 + (v % 10)));
      v = v / 10;
    end while (v > 0);
    foreach (t[i]) expQ.push_back(t[i]);
  endfunction

  function automatic void modelStr(input int addr);
    expQ.delete();
    for (int n = 0; n < 1024; n++) begin
      if (mem[(addr + n) % 4096] == 8'h00) break;
      expQ.push_back(mem[(addr + n) % 4096]);
    end
  endfunction

  function automatic void modelHex(input logic [31:0] a0);
    logic [3:0] n;
    expQ.delete();
    expQ.push_back(8'h30);
    expQ.push_back(8'h78);
    for (int i = 7; i >= 0; i--) begin
      n = a0[4*i +: 4];
      expQ.push_back(n < 4'd10 ? 8'(48 + n) : 8'(87 + n));
    end
  endfunction

  task automatic runCase(input string tag, input logic [31:0] v0, input logic [31:0] a0,
                         input int mode, input int limit, output int cycles);
    int base, d0;
    readyMode = mode;
    base = gotQ.size();
    d0 = doneCnt;
    applyStimulus(v0, a0, limit, cycles);
    compareStream(tag, base);
    checkOutput({tag, "_done"}, 64'(doneCnt - d0), 64'd1);
  endtask

  function automatic void fillStr(input int addr, input int len);
    for (int i = 0; i < len; i++) mem[(addr + i) % 4096] = 8'($urandom_range(1, 255));
    mem[(addr + len) % 4096] = 8'h00;
  endfunction

  initial begin
    #800000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc, base, d0, addr;
    logic [31:0] r;
    logic [31:0] ints [4] = '{32'd0, 32'd123, 32'hFFFF_FFD3, 32'h8000_0000};

    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    reset = 1'b1;
    bus.syscall_valid = 1'b0;
    bus.v0 = '0;
    bus.a0 = '0;
    bus.char_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_stall", {63'd0, bus.stall}, 64'd0);
    checkOutput("rst_done", {63'd0, bus.done}, 64'd0);
    checkOutput("rst_halt", {63'd0, bus.halt}, 64'd0);
    checkOutput("rst_mem_ren", {63'd0, bus.mem_ren}, 64'd0);
    checkOutput("rst_mem_addr", {32'd0, bus.mem_addr}, 64'd0);
    checkOutput("rst_char_valid", {63'd0, bus.char_valid}, 64'd0);
    checkOutput("rst_char_data", {56'd0, bus.char_data}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // "Hi!" at 0x100
    mem[12'h100] = 8'h48; mem[12'h101] = 8'h69; mem[12'h102] = 8'h21; mem[12'h103] = 8'h00;
    modelStr(32'h100);
    runCase("str_hi", 32'd4, 32'h100, 0, 200, cyc);

    // Word-crossing string with a toggling sink
    fillStr(32'h202, 9);
    modelStr(32'h202);
    runCase("str_cross", 32'd4, 32'h202, 1, 400, cyc);

    foreach (ints[i]) begin
      modelInt(ints[i]);
      runCase($sformatf("int_dir%0d", i), 32'd1, ints[i], 0, 300, cyc);
    end
    for (int i = 0; i < 6; i++) begin
      r = $urandom;
      modelInt(r);
      runCase($sformatf("int_rnd%0d", i), 32'd1, r, 2, 600, cyc);
    end

    expQ.delete();
    expQ.push_back(8'h41);
    runCase("char", 32'd11, 32'h0000_0A41, 0, 50, cyc);
    checkOutput("char_latency", 64'(cyc), 64'd3);

    expQ.delete();
    runCase("nop7", 32'd7, 32'h1234, 0, 50, cyc);
    checkOutput("nop_latency", 64'(cyc), 64'd2);

    for (int i = 0; i < 5; i++) begin
      addr = $urandom_range(0, 3000);
      fillStr(addr, $urandom_range(1, 12));
      modelStr(addr);
      runCase($sformatf("str_rnd%0d", i), 32'd4, 32'(addr), 2, 800, cyc);
    end

    // Unterminated run longer than the per-call limit
    fillStr(32'h800, 1100);
    modelStr(32'h800);
    runCase("str_trunc", 32'd4, 32'h800, 0, 20000, cyc);

`ifdef SYSCALL_HEX_EN
    modelHex(32'hDEAD_BEEF);
    runCase("hex", 32'd34, 32'hDEAD_BEEF, 1, 200, cyc);
    r = $urandom;
    modelHex(r);
    runCase("hex_rnd", 32'd34, r, 2, 200, cyc);
`else
    expQ.delete();
    runCase("hex_off", 32'd34, 32'hDEAD_BEEF, 0, 50, cyc);
    checkOutput("hex_off_latency", 64'(cyc), 64'd2);
`endif

    // Reset during a string after two bytes with the sink stalled
    fillStr(32'h300, 20);
    modelStr(32'h300);
    readyMode = 0;
    base = gotQ.size();
    @(posedge clk); #1;
    bus.v0 = 32'd4;
    bus.a0 = 32'h300;
    bus.syscall_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (gotQ.size() - base >= 2) break;
    end
    readyMode = 3;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("mid_valid_held", {63'd0, bus.char_valid}, 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.syscall_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid_rst_valid", {63'd0, bus.char_valid}, 64'd0);
    checkOutput("mid_rst_stall", {63'd0, bus.stall}, 64'd0);
    reset = 1'b0;
    readyMode = 0;
    repeat (20) @(posedge clk);
    checkOutput("mid_rst_count", 64'(gotQ.size() - base), 64'd2);
    if (gotQ.size() - base >= 2) begin
      checkOutput("mid_rst_b0", {56'd0, gotQ[base]}, {56'd0, expQ[0]});
      checkOutput("mid_rst_b1", {56'd0, gotQ[base + 1]}, {56'd0, expQ[1]});
    end

    // Exit, then ignored syscalls, then reset clears halt
    expQ.delete();
    runCase("exit", 32'd10, 32'd0, 0, 50, cyc);
    checkOutput("halt_set", {63'd0, bus.halt}, 64'd1);
    base = gotQ.size();
    d0 = doneCnt;
    bus.v0 = 32'd1;
    bus.a0 = 32'd5;
    bus.syscall_valid = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("halt_sticky", {63'd0, bus.halt}, 64'd1);
    checkOutput("halt_stall", {63'd0, bus.stall}, 64'd0);
    @(posedge clk); #1 bus.syscall_valid = 1'b0;
    checkOutput("halt_no_bytes", 64'(gotQ.size() - base), 64'd0);
    checkOutput("halt_no_done", 64'(doneCnt - d0), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("halt_cleared", {63'd0, bus.halt}, 64'd0);

    expQ.delete();
    expQ.push_back(8'h5A);
    runCase("char_after", 32'd11, 32'h5A, 2, 50, cyc);

    checkOutput("hold_violations", 64'(holdViol), 64'd0);
    checkOutput("stall_on_done", 64'(stallDoneViol), 64'd0);
    checkOutput("addr_unaligned", 64'(addrViol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
